// File: rtl/switch_debounce.sv
// switch_debounce: synchronise and debounce active-low switch inputs into clean levels and one-cycle pulses
// Ports: HCLK clock; HRESET sync active-high reset; nSwitch_in raw active-low inputs;
//        Switch_level debounced active-high level; Switch_press/Switch_release one-cycle edge pulses;
//        Switch_long one-cycle long-press pulse (only when built with LONG_PRESS_EN, else constant 0).
module switch_debounce #(
    parameter int N_CH              = 4,
    parameter int DEBOUNCE_CYCLES   = 1024,
    parameter int LONG_PRESS_CYCLES = 65536
) (
    input  logic            HCLK,
    input  logic            HRESET,
    input  logic [N_CH-1:0] nSwitch_in,
    output logic [N_CH-1:0] Switch_level,
    output logic [N_CH-1:0] Switch_press,
    output logic [N_CH-1:0] Switch_release,
    output logic [N_CH-1:0] Switch_long
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [N_CH-1:0] sync1_q, sync2_q, raw_p, stable_q, stable_d, press_q, rel_q;
    logic [N_CH-1:0][CW-1:0] cnt_q, cnt_d;
    assign raw_p = ~sync2_q;
    // A counter at its last value implies the previous sample mismatched, so the
    // current sample is either the confirmed new level or equal to the old one.
    always_comb begin
        stable_d = stable_q;
        cnt_d = cnt_q;
        for (int i = 0; i < N_CH; i++) begin
            stable_d[i] = (cnt_q[i] == CNT_LAST) ? raw_p[i] : stable_q[i];
            cnt_d[i] = (raw_p[i] == stable_q[i] || cnt_q[i] == CNT_LAST) ? '0 : cnt_q[i] + 1'b1;
        end
    end
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync1_q <= '1;
            sync2_q <= '1;
            stable_q <= '0;
            cnt_q <= '0;
            press_q <= '0;
            rel_q <= '0;
        end else begin
            sync1_q <= nSwitch_in;
            sync2_q <= sync1_q;
            stable_q <= stable_d;
            cnt_q <= cnt_d;
            press_q <= stable_d & ~stable_q;
            rel_q <= stable_q & ~stable_d;
        end
    end
    assign Switch_level = stable_q;
    assign Switch_press = press_q;
    assign Switch_release = rel_q;
`ifdef LONG_PRESS_EN
    localparam int LW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [LW-1:0] HOLD_MAX = LW'(LONG_PRESS_CYCLES);
    localparam logic [LW-1:0] HOLD_FIRE = LW'(LONG_PRESS_CYCLES - 1);
    logic [N_CH-1:0][LW-1:0] hold_q, hold_d;
    // Counting only while the level stays 1 across the edge keeps the counter at 0
    // in the press cycle and clears it in the release cycle.
    always_comb begin
        hold_d = hold_q;
        Switch_long = '0;
        for (int i = 0; i < N_CH; i++) begin
            hold_d[i] = !(stable_d[i] && stable_q[i]) ? '0 : (hold_q[i] == HOLD_MAX) ? hold_q[i] : hold_q[i] + 1'b1;
            Switch_long[i] = stable_q[i] && hold_q[i] == HOLD_FIRE;
        end
    end
    always_ff @(posedge HCLK) begin
        if (HRESET) hold_q <= '0;
        else hold_q <= hold_d;
    end
`else
    // The long-press length only matters with hold counters; any legal value (>= 1) makes this 0.
    assign Switch_long = {N_CH{LONG_PRESS_CYCLES < 1}};
`endif
endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Front-end conditioning stage for the cycle computer's raw push-button and reed-switch inputs (nMode, nTrip, nFork, nCrank).
- Synchronises each asynchronous active-low input to HCLK and debounces it with a per-channel stability counter.
- Emits a clean active-high level plus single-cycle press and release pulses per channel.
- Sits directly upstream of input_soc, which consumes the pulses for its switch-count and period measurements.

Parameters:
- N_CH, 4, number of switch channels; bit order {nCrank, nFork, nTrip, nMode} = {3,2,1,0}.
- DEBOUNCE_CYCLES, 1024, consecutive stable HCLK cycles required to accept a new level; legal range 1..65535.
- LONG_PRESS_CYCLES, 65536, stable-pressed cycles before a long-press pulse; used only with LONG_PRESS_EN; must be >= 1.

Ports:
- HCLK  input  1  system clock; all state on rising edge.
- HRESET  input  1  synchronous active-high reset.
- nSwitch_in  input  N_CH  raw asynchronous switch inputs, active-low (0 = pressed).
- Switch_level  output  N_CH  debounced level, active-high (1 = pressed).
- Switch_press  output  N_CH  one-cycle pulse when Switch_level rises.
- Switch_release  output  N_CH  one-cycle pulse when Switch_level falls.
- Switch_long  output  N_CH  one-cycle long-press pulse; tied 0 without LONG_PRESS_EN.

Behaviour:
- Reset (HRESET=1 at a rising edge):
  - Sync flops load 1 (released); stable state 0; debounce counters 0.
  - All outputs 0 from the next cycle, regardless of nSwitch_in.
  - Reset mid-bounce or mid-hold discards all progress; no press or release pulse is generated across reset.
- Synchroniser: 2-flop chain per channel; sync_n = second stage; raw_p = ~sync_n.
- Debounce, per channel, independent:
  - Counter width $clog2(DEBOUNCE_CYCLES+1).
  - If raw_p == stable: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: stable <= raw_p, counter <= 0.
  - Else: counter <= counter+1.
  - Any single-cycle return to the old level restarts the count from 0; glitches shorter than DEBOUNCE_CYCLES never propagate.
- Latency: a clean raw edge sampled at edge k appears on Switch_level after edge k+1+DEBOUNCE_CYCLES. Fixed: 2 sync cycles plus DEBOUNCE_CYCLES-1 count cycles.
- Switch_level is the registered stable state.
- Pulses:
  - Switch_press is 1 for exactly the one cycle in which Switch_level first reads 1.
  - Switch_release is the same for the 1->0 transition.
  - Both are registered outputs, never combinational from nSwitch_in.
  - Press and release on the same channel can never coincide.
  - Different channels may pulse in the same cycle; there is no arbitration.
- DEBOUNCE_CYCLES=1: a new level is accepted after one mismatching synced sample, so latency is 2 edges.

Optional Feature:
- Macro: LONG_PRESS_EN.
- Defined:
  - Per-channel hold counter, width $clog2(LONG_PRESS_CYCLES+1), reset to 0.
  - Increments each cycle Switch_level=1 and saturates at LONG_PRESS_CYCLES.
  - Switch_long pulses for one cycle on the cycle the counter reaches LONG_PRESS_CYCLES-1 (the LONG_PRESS_CYCLES-th pressed cycle, counting the Switch_press cycle as 1).
  - Counter clears to 0 in the cycle Switch_level is 0.
  - Exactly one Switch_long per press, however long the hold.
- Not defined: no hold counters are synthesised; Switch_long is constant 0.

Test Plan (DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32 overridden):
- Clean press: drive nSwitch_in[0] 1->0 before edge k and hold -> Switch_level[0]=1 from edge k+9; Switch_press[0]=1 for that single cycle; other channels stay 0.
- Bounce: toggle nSwitch_in[2] every 3 cycles for 30 cycles, then hold 0 -> no pulses during the bounce; a single Switch_press[2] 9 edges after the final settle.
- Release and simultaneity: release ch0 and press ch3 on the same edge -> Switch_release[0] and Switch_press[3] both pulse in the same cycle.
- Reset mid-operation: assert HRESET for 1 cycle while ch1 counter=5 and ch0 is pressed -> all outputs 0 next cycle. Ch0, still held 0, re-presses 2+8 edges after HRESET deasserts; no release pulse is emitted.
- Long press (LONG_PRESS_EN): hold ch1 for 100 cycles after Switch_press -> one Switch_long[1] on the 32nd pressed cycle and none after. Release and re-press -> a new Switch_long 32 cycles after the new Switch_press. Without the macro, Switch_long stays 0 throughout.
- Short glitch: a 7-cycle low pulse on nSwitch_in[3] -> no change on any output.
